// File: rtl/uart_tx_arbiter_if.sv
// Bus between the requesters, the UART transmit core and the arbiter that shares it.
// slave: arbiter side; master: requesters plus core busy status.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      owner_id;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 timeout_err;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, owner_id, tx_start, tx_data, timeout_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, owner_id, tx_start, tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit core among NUM_REQ
// requesters; sequences the core start/busy handshake and evicts stalled owners.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset_sys,
    uart_tx_arbiter_if.slave bus
);
    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [ID_W+1:0]   NUM_REQ_W = (ID_W + 2)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LOCKED, WAIT_ACK, WAIT_DONE} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     last_owner_q, last_owner_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_err_q, timeout_err_d;

    logic [7:0]             data_arr [NUM_REQ];
    logic [2*NUM_REQ-1:0]   valid_dbl;
    logic [NUM_REQ-1:0]     valid_rot;
    logic [ID_W:0]          start_idx;
    logic [ID_W-1:0]        pick_off;
    logic [ID_W+1:0]        pick_sum;
    logic [ID_W-1:0]        pick_id;
    logic                   pick_found;
    logic                   owner_valid;
    logic                   owner_accept;
    logic [CNT_W-1:0]       cnt_inc;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
        assign data_arr[gi] = bus.req_data[8*gi +: 8];
    end

    // Rotate the request vector so bit 0 is the requester after the last owner;
    // a shift by NUM_REQ lands on the upper copy, which is the wrap case.
    assign start_idx = {1'b0, last_owner_q} + 1'b1;
    assign valid_dbl = {bus.req_valid, bus.req_valid};
    assign valid_rot = NUM_REQ'(valid_dbl >> start_idx);

    always_comb begin
        pick_found = 1'b0;
        pick_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                pick_found = 1'b1;
                pick_off   = ID_W'(i);
            end
        end
    end

    assign pick_sum = {1'b0, start_idx} + (ID_W + 2)'(pick_off);
    assign pick_id  = (pick_sum >= NUM_REQ_W) ? ID_W'(pick_sum - NUM_REQ_W) : ID_W'(pick_sum);

    assign owner_valid  = bus.req_valid[owner_q];
    assign owner_accept = (state_q == LOCKED) && owner_valid && !bus.tx_busy;
    assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = NUM_REQ'(1) << pick_id;
                    owner_d = pick_id;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (owner_accept) begin
                    tx_data_d  = data_arr[owner_q];
                    tx_start_d = 1'b1;
                    last_d     = bus.req_last[owner_q];
                    cnt_d      = '0;
                    state_d    = WAIT_ACK;
                end else if (!owner_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        timeout_err_d = 1'b1;
                        grant_d       = '0;
                        last_owner_d  = owner_q;
                        cnt_d         = '0;
                        state_d       = IDLE;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        grant_d      = '0;
                        last_owner_d = owner_q;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_sys) begin
        if (!reset_sys) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            last_owner_q  <= ID_W'(NUM_REQ - 1);
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.req_ready   = owner_accept ? grant_q : '0;
    assign bus.grant       = grant_q;
    assign bus.owner_id    = owner_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
